// File: rtl/lifo_pkg.sv
// Shared constants and helpers for the lifo_stack block.
package lifo_pkg;

    localparam int unsigned POLICY_DROP      = 0;
    localparam int unsigned POLICY_OVERWRITE = 1;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Storage array for lifo_stack: one synchronous write port, one asynchronous read port.
module lifo_stack_mem
    import lifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered pop output, status and optional overwrite ring.
// Define LIFO_STACK_ERR_EN to build the sticky overflow/underflow flags.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OVERWRITE = POLICY_DROP
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          write_i,
    input  logic                          read_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          clr_err_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          data_valid_o,
    output logic [DATA_W-1:0]             top_o,
    output logic [clog2(DEPTH+1)-1:0]     count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int unsigned CW = clog2(DEPTH + 1);
    localparam int unsigned IW = clog2(DEPTH);
    localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     base_q, base_d, top_idx, wr_idx, waddr;
    logic [DATA_W-1:0] data_q, data_d, rdata;
    logic              valid_q, valid_d, we, ovf_ev, udf_ev;
    logic [CW:0]       top_sum, wr_sum;
    logic              full, empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Indices wrap by compare-and-subtract so DEPTH need not be a power of two.
    assign top_sum = (CW+1)'(base_q) + (CW+1)'(count_q) - (CW+1)'(1);
    assign wr_sum  = (CW+1)'(base_q) + (CW+1)'(count_q);
    assign top_idx = (top_sum >= DepthW) ? IW'(top_sum - DepthW) : IW'(top_sum);
    assign wr_idx  = (wr_sum >= DepthW) ? IW'(wr_sum - DepthW) : IW'(wr_sum);

    always_comb begin
        count_d = count_q;
        base_d  = base_q;
        data_d  = data_q;
        valid_d = 1'b0;
        we      = 1'b0;
        waddr   = top_idx;
        ovf_ev  = 1'b0;
        udf_ev  = 1'b0;
        unique case ({write_i, read_i})
            2'b11: begin
                valid_d = 1'b1;
                if (empty) begin
                    data_d = data_i;
                end else begin
                    data_d = rdata;
                    we     = 1'b1;
                end
            end
            2'b10: begin
                if (!full) begin
                    we      = 1'b1;
                    waddr   = wr_idx;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_ev = 1'b1;
                    if (OVERWRITE == POLICY_OVERWRITE) begin
                        we     = 1'b1;
                        waddr  = base_q;
                        base_d = (base_q == IW'(DEPTH - 1)) ? '0 : base_q + IW'(1);
                    end
                end
            end
            2'b01: begin
                if (!empty) begin
                    data_d  = rdata;
                    valid_d = 1'b1;
                    count_d = count_q - CW'(1);
                end else begin
                    udf_ev = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            base_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            base_q  <= base_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    lifo_stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (data_i),
        .raddr_i (top_idx),
        .rdata_o (rdata)
    );

`ifdef LIFO_STACK_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A new event wins over a coincident clear.
    assign ovf_d = ovf_ev | (ovf_q & ~clr_err_i);
    assign udf_d = udf_ev | (udf_q & ~clr_err_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
`else
    logic unused_err;
    assign unused_err  = ^{clr_err_i, ovf_ev, udf_ev};
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign top_o        = empty ? '0 : rdata;
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = empty;

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised last-in/first-out stack, the successor to the fixed 8×8 LIFO buffer. It adds:
- a registered pop output with a valid strobe
- full/empty/count status and a combinational top-of-stack peek
- defined simultaneous push/pop behaviour
- a selectable overflow policy: drop the new word, or overwrite the oldest word as a ring

It sits between a producer and a consumer that share one clock domain.

## Interface
- DEPTH, 8, number of entries; ≥2, any integer.
- DATA_W, 8, word width in bits.
- OVERWRITE, 0, push-when-full policy: 0 = drop incoming word; 1 = overwrite oldest entry.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- write  in  1  push request.
- read  in  1  pop request.
- data_in  in  DATA_W  push data.
- clr_err  in  1  clears sticky error flags.
- data_out  out  DATA_W  registered popped word.
- data_valid  out  1  one-cycle strobe, data_out updated by a successful pop.
- top  out  DATA_W  combinational peek of current top entry; 0 when empty.
- count  out  CW = clog2(DEPTH+1)  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a push lost data.
- underflow  out  1  sticky: a pop found the stack empty.

## Operation
- State: storage mem[DEPTH], base index (oldest entry), and count.
- Top index = (base + count − 1) mod DEPTH. Wrap uses an explicit compare against DEPTH−1, so no power-of-two requirement.
- Push only, not full: mem[(base+count) mod DEPTH] ← data_in; count+1.
- Push only, full, OVERWRITE=0: word dropped; state unchanged; overflow event.
- Push only, full, OVERWRITE=1: mem[base] ← data_in; base+1 mod DEPTH; count stays DEPTH; overflow event (oldest word lost).
- Pop only, not empty: data_out ← mem[top]; data_valid=1; count−1.
- Pop only, empty: data_out holds; data_valid=0; underflow event.
- Push+pop, empty: pass-through. data_out ← data_in; data_valid=1; count stays 0; no memory write; no error.
- Push+pop, not empty: replace-top. data_out ← old mem[top]; mem[top] ← data_in; data_valid=1; count unchanged; no error, even when full.
- Neither request: state held; data_valid=0.

## Timing
- Reset asserted: count=0, base=0, data_out=0, data_valid=0, overflow=0, underflow=0, hence empty=1, full=0, top=0. Memory contents are not reset.
- Reset assertion mid-operation discards all entries immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.
- Pop latency is 1 cycle: the edge that samples read updates data_out/data_valid. data_valid is high for exactly one cycle per accepted pop.
- count, full, empty and base update on the same edge as the request. top reflects the new state combinationally after that edge.
- There is no back-pressure. Requests are sampled every cycle, and the requester checks full/empty.
- Error flags set on the edge of the event.
- clr_err clears both flags on the next edge. If an event coincides with clr_err, the flag remains set (set wins).

## Configuration
- LIFO_STACK_ERR_EN defined: overflow/underflow are sticky registers as described; clr_err is active.
- LIFO_STACK_ERR_EN undefined: overflow and underflow are tied to 0, clr_err is ignored, and no error registers are built. Ports remain present so the instance wiring does not change.

## Structure
- Package lifo_pkg:
  - localparams POLICY_DROP=0 and POLICY_OVERWRITE=1
  - a clog2 width function used for CW and the index width
- Sub-module lifo_stack_mem: DEPTH×DATA_W array with one synchronous write port and one asynchronous read port; it serves both top and data_out.
- lifo_stack holds pointer/count logic, the request decode and the error flags.

## Test plan
All scenarios use DEPTH=4, DATA_W=8.
- Reset pulse mid-fill (count=2) -> count=0, empty=1, top=0x00, data_out=0x00, data_valid=0 with no clock edge.
- Push 0xA1,0xB2,0xC3; then pop ×3 -> data_out 0xC3,0xB2,0xA1, each one cycle after read with a data_valid pulse; then empty=1.
- OVERWRITE=0: push 0x11,0x22,0x33,0x44,0x55 -> full=1, count=4, overflow=1, top=0x44; pops return 0x44,0x33,0x22,0x11.
- OVERWRITE=1: same pushes -> count=4, overflow=1; pops return 0x55,0x44,0x33,0x22, then empty; 0x11 lost; base wrap exercised.
- Push+pop: on empty with 0x7E -> data_out=0x7E, data_valid=1, count=0. At count=2 with top 0x22, write 0x99 -> data_out=0x22, top=0x99, count=2.
- Pop on empty -> underflow=1, data_valid=0, data_out held. clr_err alone clears it. clr_err coinciding with another empty pop leaves underflow=1.
